resp_arb_buffer: RTL and testbench
==================================

RESP_ARB_BUFFER -- requirements
Module: resp_arb_buffer

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of R-channel sources (1..16).
REQ-002 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, AXI data width.
REQ-004 SHALL have parameter RESP_WIDTH, default 2, AXI resp width.
REQ-005 SHALL have parameter TAG_WIDTH, default 4, internal tag width.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, beat storage; power of 2, at least 2.
REQ-007 SHALL have parameter AFULL_THRESH, default 12, almost-full occupancy level.
REQ-008 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-009 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port in_valid, input, NUM_SRC, per-source beat valid.
REQ-011 SHALL have port in_ready, output, NUM_SRC, per-source beat ready.
REQ-012 SHALL have ports in_id, in_data, in_resp, in_last, in_tagid, input, NUM_SRC times field width, packed per-source beat fields.
REQ-013 SHALL have port out_if, r_if.sender, -, merged output beat to core/ROB.
REQ-014 SHALL have port out_src, output, max(1,$clog2(NUM_SRC)), source index of the current out_if beat.
REQ-015 SHALL have port occupancy, output, $clog2(FIFO_DEPTH)+1, stored beat count, excluding the output register.
REQ-016 SHALL have port almost_full, output, 1, high when occupancy >= AFULL_THRESH.
REQ-017 SHALL have port err_count, output, 16, error-response counter (see Configuration).

Function
REQ-018 SHALL use a two-state arbiter FSM: IDLE and LOCKED.
REQ-019 In IDLE, SHALL grant combinationally the first valid source at or after rr_ptr, scanning upward with wrap-around.
REQ-020 In LOCKED, SHALL grant only locked_src, regardless of other valids.
REQ-021 SHALL assert in_ready[g] only for the granted source g, and only when occupancy < FIFO_DEPTH; in_ready SHALL NOT depend on out_if.ready.
REQ-022 SHALL make in_ready of every non-granted source 0.
REQ-023 An accepted beat (valid & ready) with last=0 SHALL take the FSM to LOCKED and set locked_src=g; remaining in LOCKED until the beat with last=1 is accepted.
REQ-024 An accepted beat with last=1 SHALL take the FSM to IDLE and set rr_ptr=(g+1) mod NUM_SRC.
REQ-025 Each accepted beat SHALL be written to the FIFO with {id,data,resp,last,tagid,src}; beat order SHALL be preserved.
REQ-026 FIFO pop SHALL occur when occupancy>0 and (!out_if.valid or out_if.ready); the popped beat SHALL load the output register and set out_if.valid=1.
REQ-027 When out_if.valid & out_if.ready and no pop occurs, out_if.valid SHALL be cleared at the next edge.
REQ-028 While out_if.valid=1 and out_if.ready=0, all out_if fields and out_src SHALL hold stable.
REQ-029 Latency SHALL be 2 cycles from an input handshake edge to out_if.valid into an empty block; sustained throughput SHALL be 1 beat/cycle.
REQ-030 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-031 When full, no push SHALL occur even if a pop occurs in the same cycle.
REQ-032 Pointer wrap SHALL be modulo FIFO_DEPTH.

Reset
REQ-033 On rst, SHALL reset: FSM=IDLE, rr_ptr=0, locked_src=0, FIFO pointers=0, occupancy=0, almost_full=0, out_if.valid=0, out_src=0, out_if data fields=0, err_count=0.
REQ-034 Assertion of rst mid-burst SHALL discard all buffered and partial beats; no beat SHALL emerge after deassertion until a new input handshake.

Configuration
REQ-035 With IRB_ERR_CNT_EN defined, err_count SHALL increment by 1 on each accepted input beat with resp[1]=1 (SLVERR/DECERR), saturating at 16'hFFFF.
REQ-036 Without IRB_ERR_CNT_EN, err_count SHALL be tied to 0 and no counter logic SHALL be built.

Structure
REQ-037 Package irb_pkg SHALL hold arb_state_t (IDLE, LOCKED) and AXI resp constants (OKAY, EXOKAY, SLVERR, DECERR).
REQ-038 Round-robin grant SHALL be a sub-module rr_arbiter (NUM_SRC request, rr_ptr in, one-hot grant and index out); the storage SHALL reuse the existing fifo module.

Verification (NUM_SRC=4, FIFO_DEPTH=4, AFULL_THRESH=3)
REQ-039 Single beat src2, data=0xA5, last=1, out_if.ready=1 -> out_if.valid 2 cycles later, data=0xA5, out_src=2, rr_ptr=3.
REQ-040 src0 (3-beat burst) and src1 valid together -> src0 beats 0,1,2 back-to-back, in_ready[1]=0 until src0 last accepted, then src1 granted.
REQ-041 out_if.ready=0, stream 5 beats -> occupancy reaches 4, almost_full=1 at occupancy 3, in_ready=0 at 4, output register holds beat 0 stable.
REQ-042 Full FIFO, then out_if.ready=1 with input valid -> no push in the pop cycle, push next cycle; order matches input.
REQ-043 rst pulse during 2nd beat of a burst -> out_if.valid=0, occupancy=0, FSM IDLE, rr_ptr=0.
REQ-044 With IRB_ERR_CNT_EN, beats resp=2,3,0,1 -> err_count=2; without the macro -> err_count=0.

Source files
------------

// File: rtl/irb_pkg.sv
// irb_pkg: arbiter state encoding and AXI response codes shared by the response buffer.
package irb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  localparam logic [1:0] OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3;
endpackage

// File: rtl/r_if.sv
// r_if: AXI R-channel beat bundle with sender/receiver views.
interface r_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int TAG_WIDTH  = 4
);
  logic                  valid, ready, last;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic [TAG_WIDTH-1:0]  tagid;
  modport sender(output valid, id, data, resp, last, tagid, input ready);
  modport receiver(input valid, id, data, resp, last, tagid, output ready);
endinterface

// File: rtl/fifo.sv
// fifo: synchronous FIFO with combinational read port; caller never pushes when full or pops when empty.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: grants the first requester at or after ptr, scanning upward with wrap-around.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SW-1:0]      ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [SW-1:0]      idx,
  output logic               any
);
  int j;
  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = SW'(j);
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/resp_arb_buffer.sv
// resp_arb_buffer: burst-locked round-robin merge of R-channel sources into a FIFO and output register.
// Define IRB_ERR_CNT_EN to build the saturating error-response counter.
module resp_arb_buffer import irb_pkg::*; #(
  parameter int NUM_SRC      = 4,
  parameter int ID_WIDTH     = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int RESP_WIDTH   = 2,
  parameter int TAG_WIDTH    = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_THRESH = 12,
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SRC-1:0]               in_valid,
  output logic [NUM_SRC-1:0]               in_ready,
  input  logic [NUM_SRC*ID_WIDTH-1:0]      in_id,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    in_data,
  input  logic [NUM_SRC*RESP_WIDTH-1:0]    in_resp,
  input  logic [NUM_SRC-1:0]               in_last,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]     in_tagid,
  r_if.sender                              out_if,
  output logic [SW-1:0]                    out_src,
  output logic [$clog2(FIFO_DEPTH):0]      occupancy,
  output logic                             almost_full,
  output logic [15:0]                      err_count
);
  localparam int BW = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1 + TAG_WIDTH + SW;
  arb_state_t state;
  logic [SW-1:0] rr_ptr, locked_src, arb_idx, g, r_src;
  logic [NUM_SRC-1:0] arb_grant;
  logic arb_any, full, push, pop, b_last, r_last;
  logic [ID_WIDTH-1:0] b_id, r_id;
  logic [DATA_WIDTH-1:0] b_data, r_data;
  logic [RESP_WIDTH-1:0] b_resp, r_resp;
  logic [TAG_WIDTH-1:0] b_tag, r_tag;
  logic [BW-1:0] rdata;
  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req(in_valid), .ptr(rr_ptr), .grant(arb_grant), .idx(arb_idx), .any(arb_any)
  );
  assign g           = state == LOCKED ? locked_src : arb_idx;
  assign full        = int'(occupancy) == FIFO_DEPTH;
  assign almost_full = int'(occupancy) >= AFULL_THRESH;
  // A locked burst owns the grant even while its source is momentarily idle.
  assign in_ready = {NUM_SRC{!full}} & (state == LOCKED ? NUM_SRC'(1) << locked_src : arb_grant);
  assign push     = |(in_valid & in_ready);
  assign pop      = occupancy != '0 && (!out_if.valid || out_if.ready);
  assign b_id     = in_id[g*ID_WIDTH +: ID_WIDTH];
  assign b_data   = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  assign b_resp   = in_resp[g*RESP_WIDTH +: RESP_WIDTH];
  assign b_last   = in_last[g];
  assign b_tag    = in_tagid[g*TAG_WIDTH +: TAG_WIDTH];
  assign {r_id, r_data, r_resp, r_last, r_tag, r_src} = rdata;
  fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wdata({b_id, b_data, b_resp, b_last, b_tag, g}), .rdata(rdata), .count(occupancy)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      locked_src <= '0;
    end else if (push) begin
      state <= b_last ? IDLE : LOCKED;
      if (!b_last) locked_src <= g;
      if (b_last) rr_ptr <= g == SW'(NUM_SRC - 1) ? '0 : g + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_if.valid <= 1'b0;
      out_if.id    <= '0;
      out_if.data  <= '0;
      out_if.resp  <= '0;
      out_if.last  <= 1'b0;
      out_if.tagid <= '0;
      out_src      <= '0;
    end else if (pop) begin
      out_if.valid <= 1'b1;
      out_if.id    <= r_id;
      out_if.data  <= r_data;
      out_if.resp  <= r_resp;
      out_if.last  <= r_last;
      out_if.tagid <= r_tag;
      out_src      <= r_src;
    end else if (out_if.ready) out_if.valid <= 1'b0;
`ifdef IRB_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else if (push && b_resp[1] && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_resp_arb_buffer.sv
// tb_resp_arb_buffer: queue-based reference model compared every cycle, plus directed scenarios with literal expectations.
module tb_resp_arb_buffer;
  localparam int N = 4, IW = 4, DW = 64, RW = 2, TW = 4, D = 4, AF = 3;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [RW-1:0] resp;
    logic          last;
    logic [TW-1:0] tag;
    logic [1:0]    src;
  } beat_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid, in_ready, in_last;
  logic [N*IW-1:0] in_id;
  logic [N*DW-1:0] in_data;
  logic [N*RW-1:0] in_resp;
  logic [N*TW-1:0] in_tagid;
  logic [1:0]      out_src;
  logic [2:0]      occupancy;
  logic            almost_full;
  logic [15:0]     err_count;

  r_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .TAG_WIDTH(TW)) rif ();

  resp_arb_buffer #(
    .NUM_SRC(N), .ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .TAG_WIDTH(TW),
    .FIFO_DEPTH(D), .AFULL_THRESH(AF)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_data(in_data), .in_resp(in_resp), .in_last(in_last), .in_tagid(in_tagid),
    .out_if(rif), .out_src(out_src), .occupancy(occupancy), .almost_full(almost_full),
    .err_count(err_count)
  );

  int errors = 0, checks = 0;
  beat_t sb[N];
  logic  sv[N];
  int    rem[N];
  logic  oready;

  beat_t mq[$];
  beat_t mout;
  bit    mov, mlock;
  int    mls, mptr, merr, last_g;
  logic [N-1:0] erdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int s, input bit l);
    beat_t b;
    b.id   = IW'($urandom);
    b.data = {$urandom, $urandom};
    b.resp = RW'($urandom);
    b.last = l;
    b.tag  = TW'($urandom);
    b.src  = 2'(s);
    return b;
  endfunction

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      in_valid[s]           = sv[s];
      in_id[s*IW +: IW]     = sb[s].id;
      in_data[s*DW +: DW]   = sb[s].data;
      in_resp[s*RW +: RW]   = sb[s].resp;
      in_last[s]            = sb[s].last;
      in_tagid[s*TW +: TW]  = sb[s].tag;
    end
    rif.ready = oready;
  endtask

  task automatic model_reset();
    mq.delete();
    mout  = '0;
    mov   = 1'b0;
    mlock = 1'b0;
    mls   = 0;
    mptr  = 0;
    merr  = 0;
  endtask

  // Granted source: the locked burst owner, else first valid at or after the pointer.
  function automatic logic [N-1:0] calc_ready();
    logic [N-1:0] r = '0;
    if (mlock) r[mls] = 1'b1;
    else
      for (int i = 0; i < N; i++)
        if (sv[(mptr + i) % N]) begin
          r[(mptr + i) % N] = 1'b1;
          break;
        end
    if (mq.size() == D) r = '0;
    return r;
  endfunction

  task automatic pre();
    drive();
    #1;
    erdy = calc_ready();
    chk("in_ready", 64'(in_ready), 64'(erdy));
    chk("out_valid", 64'(rif.valid), 64'(mov));
    if (mov) begin
      chk("out_id", 64'(rif.id), 64'(mout.id));
      chk("out_data", rif.data, mout.data);
      chk("out_resp", 64'(rif.resp), 64'(mout.resp));
      chk("out_last", 64'(rif.last), 64'(mout.last));
      chk("out_tagid", 64'(rif.tagid), 64'(mout.tag));
      chk("out_src", 64'(out_src), 64'(mout.src));
    end
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("almost_full", 64'(almost_full), 64'(mq.size() >= AF));
    chk("err_count", 64'(err_count), 64'(merr));
  endtask

  task automatic post();
    beat_t b;
    @(posedge clk);
    last_g = -1;
    for (int s = 0; s < N; s++) if (sv[s] && erdy[s]) last_g = s;
    if (mq.size() > 0 && (!mov || oready)) begin
      mout = mq.pop_front();
      mov  = 1'b1;
    end else if (oready) mov = 1'b0;
    if (last_g >= 0) begin
      b = sb[last_g];
      b.src = 2'(last_g);
      mq.push_back(b);
      if (b.last) begin
        mlock = 1'b0;
        mptr  = (last_g + 1) % N;
      end else begin
        mlock = 1'b1;
        mls   = last_g;
      end
`ifdef IRB_ERR_CNT_EN
      if (b.resp[1] && merr < 65535) merr++;
`endif
    end
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    repeat (8) begin
      pre();
      post();
    end
  endtask

  initial begin
    int n;
    logic [1:0] rs[4];
    rs = '{2'd2, 2'd3, 2'd0, 2'd1};
    for (int s = 0; s < N; s++) begin
      sv[s] = 1'b0;
      sb[s] = '0;
      rem[s] = 0;
    end
    oready = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(rif.valid), 64'd0);
    chk("rst_data", rif.data, 64'd0);
    chk("rst_id", 64'(rif.id), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_afull", 64'(almost_full), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    rst = 1'b0;
    model_reset();

    // Burst from src0 locks out src1 until its last beat
    oready = 1'b1;
    sv[0] = 1'b1;
    sv[1] = 1'b1;
    sb[1] = mk(1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      sb[0] = mk(0, k == 2);
      pre();
      chk("burst_grant_src0", 64'(in_ready), 64'b0001);
      post();
    end
    sv[0] = 1'b0;
    pre();
    chk("after_burst_src1", 64'(in_ready), 64'b0010);
    post();
    sv[1] = 1'b0;
    drain();

    // Single beat from src2: two-cycle latency and pointer advance to 3
    sb[2] = mk(2, 1'b1);
    sb[2].data = 64'hA5;
    sv[2] = 1'b1;
    pre();
    chk("single_grant", 64'(in_ready), 64'b0100);
    post();
    sv[2] = 1'b0;
    pre();
    chk("lat_cycle1_valid", 64'(rif.valid), 64'd0);
    post();
    pre();
    chk("lat_cycle2_valid", 64'(rif.valid), 64'd1);
    chk("single_data", rif.data, 64'hA5);
    chk("single_src", 64'(out_src), 64'd2);
    post();
    sv[0] = 1'b1;
    sb[0] = mk(0, 1'b1);
    sv[3] = 1'b1;
    sb[3] = mk(3, 1'b1);
    pre();
    chk("rr_ptr_3", 64'(in_ready), 64'b1000);
    post();
    sv[3] = 1'b0;
    pre();
    post();
    sv[0] = 1'b0;
    drain();

    // Back-pressure fills the FIFO while the output register holds beat 0
    oready = 1'b0;
    n = 0;
    sv[1] = 1'b1;
    sb[1] = mk(1, 1'b1);
    sb[1].data = 64'd0;
    repeat (8) begin
      pre();
      post();
      if (last_g == 1) begin
        n++;
        sb[1] = mk(1, 1'b1);
        sb[1].data = 64'(n);
      end
    end
    chk("stream_accepted", 64'(n), 64'd5);
    oready = 1'b1;
    pre();
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_afull", 64'(almost_full), 64'd1);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_hold_data", rif.data, 64'd0);
    post();
    pre();
    chk("after_pop_ready", 64'(in_ready), 64'b0010);
    chk("after_pop_occ", 64'(occupancy), 64'd3);
    post();
    sv[1] = 1'b0;
    drain();

    // Reset in the middle of a burst discards everything
    oready = 1'b0;
    sv[0] = 1'b1;
    sb[0] = mk(0, 1'b0);
    pre();
    post();
    sb[0] = mk(0, 1'b0);
    pre();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(rif.valid), 64'd0);
    chk("midrst_occ", 64'(occupancy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sv[0] = 1'b0;
    oready = 1'b1;
    pre();
    chk("postrst_valid", 64'(rif.valid), 64'd0);
    post();
    repeat (2) begin
      pre();
      post();
    end
    sv[1] = 1'b1;
    sb[1] = mk(1, 1'b1);
    sv[3] = 1'b1;
    sb[3] = mk(3, 1'b1);
    pre();
    chk("postrst_idle_ptr0", 64'(in_ready), 64'b0010);
    post();
    sv[1] = 1'b0;
    pre();
    chk("postrst_next_src3", 64'(in_ready), 64'b1000);
    post();
    sv[3] = 1'b0;
    drain();

    // Error-response counting
    pulse_rst();
    for (int k = 0; k < 4; k++) begin
      sb[0] = mk(0, 1'b1);
      sb[0].resp = rs[k];
      sv[0] = 1'b1;
      pre();
      post();
    end
    sv[0] = 1'b0;
    pre();
`ifdef IRB_ERR_CNT_EN
    chk("err_count_literal", 64'(err_count), 64'd2);
`else
    chk("err_count_literal", 64'(err_count), 64'd0);
`endif
    post();
    drain();

    // Randomized traffic
    repeat (3000) begin
      oready = ($urandom % 4) != 0;
      for (int s = 0; s < N; s++)
        if (!sv[s] && $urandom % 4 == 0) begin
          sv[s]  = 1'b1;
          rem[s] = $urandom_range(0, 3);
          sb[s]  = mk(s, rem[s] == 0);
        end
      pre();
      post();
      if (last_g >= 0) begin
        if (rem[last_g] == 0) sv[last_g] = 1'b0;
        else begin
          rem[last_g]--;
          sb[last_g] = mk(last_g, rem[last_g] == 0);
        end
      end
    end
    for (int s = 0; s < N; s++) sv[s] = 1'b0;
    oready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
